// File: rtl/bloom_pkg.sv
// bloom_pkg: operation codes, FSM states and hash seeds shared by the Bloom-filter unit.
package bloom_pkg;

    typedef enum logic [1:0] {
        INSERT = 2'b00,
        CHECK  = 2'b01,
        CLEAR  = 2'b10,
        COUNT  = 2'b11
    } bloom_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HASH,
        S_CLEAR,
        S_RESP
    } bloom_state_e;

    localparam logic [31:0] SEED [8] = '{
        32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F,
        32'h165667B1, 32'hD3A2646C, 32'hFD7046C5, 32'hB55A4F09
    };

endpackage

// File: rtl/bloom_hash.sv
// bloom_hash: multiplicative hash; index is the top IDX_W bits of the truncated data*SEED[h] product.
module bloom_hash
    import bloom_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        h,
    output logic [IDX_W-1:0]  index
);

    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] prod;

    always_comb begin
        seed  = DATA_W'(SEED[h]);
        prod  = data * seed;
        index = IDX_W'(prod >> (DATA_W - IDX_W));
    end

endmodule

// File: rtl/bloom_filter_unit.sv
// bloom_filter_unit: serial-hash Bloom filter with insert/check/clear/count over a valid/ready handshake.
// Define BLOOM_STATS_EN to add insert/population counters returned by COUNT.
module bloom_filter_unit
    import bloom_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int M_BITS = 256,
    parameter int K_HASH = 3,
    parameter int CLR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(M_BITS);
    localparam int NW    = M_BITS / CLR_W;
    localparam int WW    = NW > 1 ? $clog2(NW) : 1;

    bloom_state_e      state, state_n;
    bloom_op_e         op_q;
    logic [DATA_W-1:0] data_q;
    logic [M_BITS-1:0] bits;
    logic [2:0]        h;
    logic [WW-1:0]     w;
    logic              match;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              hash_last;
    logic [31:0]       stats;
    logic [31:0]       result;

    bloom_hash #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_hash (
        .data  (data_q),
        .h     (h),
        .index (idx)
    );

    assign req_ready_o  = state == S_IDLE;
    assign busy_o       = state != S_IDLE;
    assign resp_valid_o = state == S_RESP;
    assign accept       = req_valid_i && req_ready_o;
    assign hash_last    = state == S_HASH && h == 3'(K_HASH - 1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (req_valid_i) state_n = op_i == CLEAR ? S_CLEAR : op_i == COUNT ? S_RESP : S_HASH;
            S_HASH:  if (h == 3'(K_HASH - 1)) state_n = S_RESP;
            S_CLEAR: if (w == WW'(NW - 1)) state_n = S_RESP;
            default: state_n = S_IDLE;
        endcase
    end

    // Result is latched on entry to RESP so it stays stable until the next response.
    always_comb begin
        result = '0;
        if (state == S_HASH)      result = {31'b0, op_q == CHECK && match && bits[idx]};
        else if (state == S_IDLE) result = stats;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bits        <= '0;
            h           <= '0;
            w           <= '0;
            match       <= 1'b1;
            op_q        <= INSERT;
            data_q      <= '0;
            resp_data_o <= '0;
        end else begin
            if (accept) begin
                h      <= '0;
                w      <= '0;
                match  <= 1'b1;
                op_q   <= bloom_op_e'(op_i);
                data_q <= data_i;
            end
            if (state == S_HASH) begin
                h <= h + 3'd1;
                if (op_q == INSERT) bits[idx] <= 1'b1;
                else                match     <= match & bits[idx];
            end
            if (state == S_CLEAR) begin
                bits[w*CLR_W +: CLR_W] <= '0;
                w                      <= w + 1'b1;
            end
            if (state_n == S_RESP && state != S_RESP) resp_data_o <= result;
        end
    end

`ifdef BLOOM_STATS_EN
    logic [15:0] insert_cnt;
    logic [15:0] pop_cnt;

    assign stats = {insert_cnt, pop_cnt};

    always_ff @(posedge clk_i) begin
        if (!rst_ni || (accept && op_i == CLEAR)) begin
            insert_cnt <= '0;
            pop_cnt    <= '0;
        end else if (state == S_HASH && op_q == INSERT) begin
            if (!bits[idx]) pop_cnt <= pop_cnt + 16'd1;
            if (hash_last && insert_cnt != 16'hFFFF) insert_cnt <= insert_cnt + 16'd1;
        end
    end
`else
    assign stats = '0;
`endif

endmodule

// File: tb/tb_bloom_filter_unit.sv
// tb_bloom_filter_unit: directed table, reset-abort, held-valid and randomized checks against a set-based model.
module tb_bloom_filter_unit;

    localparam int K  = 3;
    localparam int M  = 256;
    localparam int CW = 32;
    localparam logic [1:0] OP_INS = 2'b00, OP_CHK = 2'b01, OP_CLR = 2'b10, OP_CNT = 2'b11;
    localparam logic [31:0] TB_SEED [8] = '{
        32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F,
        32'h165667B1, 32'hD3A2646C, 32'hFD7046C5, 32'hB55A4F09
    };
`ifdef BLOOM_STATS_EN
    localparam logic [31:0] CNT1 = {16'd1, 16'd3};
    localparam logic [31:0] CNT2 = {16'd2, 16'd3};
`else
    localparam logic [31:0] CNT1 = 32'd0;
    localparam logic [31:0] CNT2 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] data = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    bit [M-1:0] mbits;
    int         m_ins;
    int         m_pop;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] pool[16];
    logic [31:0] expq[$];

    bloom_filter_unit #(.DATA_W(32), .M_BITS(M), .K_HASH(K), .CLR_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_i         (op),
        .data_i       (data),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int hidx(logic [31:0] d, int i);
        logic [31:0] p;
        p = d * TB_SEED[i];
        return int'(p[31:24]);
    endfunction

    function automatic int lat_of(logic [1:0] o);
        return o == OP_CLR ? M / CW + 1 : o == OP_CNT ? 1 : K + 1;
    endfunction

    task automatic model(input logic [1:0] o, input logic [31:0] d, output logic [31:0] r);
        logic hit;
        r   = '0;
        hit = 1'b1;
        case (o)
            OP_INS: begin
                for (int i = 0; i < K; i++) begin
                    if (!mbits[hidx(d, i)]) m_pop++;
                    mbits[hidx(d, i)] = 1'b1;
                end
                if (m_ins < 65535) m_ins++;
            end
            OP_CHK: begin
                for (int i = 0; i < K; i++) hit &= mbits[hidx(d, i)];
                r = {31'b0, hit};
            end
            OP_CLR: begin
                mbits = '0;
                m_ins = 0;
                m_pop = 0;
            end
            default: begin
`ifdef BLOOM_STATS_EN
                r = {m_ins[15:0], m_pop[15:0]};
`endif
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] d, output logic [31:0] resp, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        op        = o;
        data      = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op        = 2'($urandom);
        data      = $urandom;
        lat       = 0;
        while (lat < 200) begin
            lat++;
            @(negedge clk);
            if (resp_valid) break;
            check("busy_not_ready", {30'b0, req_ready, busy}, 32'd1);
        end
        resp = resp_data;
        @(negedge clk);
        check("strobe_one_cycle", {31'b0, resp_valid}, 32'd0);
        check("resp_data_hold", resp_data, resp);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] e;
        int          lat;
        int          acc;
        int          rsp;
        logic [31:0] ins_vals[5];

        mbits = '0;
        m_ins = 0;
        m_pop = 0;
        for (int i = 0; i < 16; i++) pool[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_valid", {31'b0, resp_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_data", resp_data, 32'd0);
        rst_n = 1'b1;

        tbl.push_back('{OP_CHK, 32'h0000_1234, 32'd0, 4});
        tbl.push_back('{OP_INS, 32'h0000_1234, 32'd0, 4});
        tbl.push_back('{OP_CHK, 32'h0000_1234, 32'd1, 4});
        tbl.push_back('{OP_INS, 32'hDEAD_BEEF, 32'd0, 4});
        tbl.push_back('{OP_CLR, 32'h0,         32'd0, 9});
        tbl.push_back('{OP_CHK, 32'hDEAD_BEEF, 32'd0, 4});
        tbl.push_back('{OP_CHK, 32'h0000_1234, 32'd0, 4});
        tbl.push_back('{OP_INS, 32'h0000_0001, 32'd0, 4});
        tbl.push_back('{OP_CNT, 32'h0,         CNT1,  1});
        tbl.push_back('{OP_INS, 32'h0000_0001, 32'd0, 4});
        tbl.push_back('{OP_CNT, 32'h0,         CNT2,  1});
        tbl.push_back('{OP_CLR, 32'h0,         32'd0, 9});
        tbl.push_back('{OP_CNT, 32'h0,         32'd0, 1});
        foreach (tbl[i]) begin
            model(tbl[i].op, tbl[i].data, e);
            do_op(tbl[i].op, tbl[i].data, r, lat);
            check($sformatf("vec%0d_resp", i), r, tbl[i].exp);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
        end

        for (int i = 0; i < 5; i++) begin
            ins_vals[i] = $urandom;
            model(OP_INS, ins_vals[i], e);
            do_op(OP_INS, ins_vals[i], r, lat);
        end
        @(negedge clk);
        req_valid = 1'b1;
        op        = OP_CLR;
        data      = '0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("clear_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_valid", {31'b0, resp_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_data", resp_data, 32'd0);
        mbits = '0;
        m_ins = 0;
        m_pop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            do_op(OP_CHK, ins_vals[i], r, lat);
            check("abort_check_empty", r, 32'd0);
        end
        do_op(OP_CNT, 32'h0, r, lat);
        check("abort_count_zero", r, 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  o;
            logic [31:0] d;
            int          s;
            s = $urandom_range(0, 19);
            o = s < 8 ? OP_INS : s < 16 ? OP_CHK : s < 18 ? OP_CNT : OP_CLR;
            d = $urandom_range(0, 3) == 0 ? $urandom : pool[$urandom_range(0, 15)];
            model(o, d, e);
            do_op(o, d, r, lat);
            check($sformatf("rand%0d_op%0d_resp", i, o), r, e);
            check($sformatf("rand%0d_op%0d_lat", i, o), lat, lat_of(o));
        end

        acc = 0;
        rsp = 0;
        @(negedge clk);
        req_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            op   = c % 3 == 0 ? OP_INS : c % 3 == 1 ? OP_CHK : OP_CNT;
            data = pool[$urandom_range(0, 15)];
            check("hold_ready_vs_busy", {31'b0, req_ready}, {31'b0, !busy});
            if (resp_valid) begin
                rsp++;
                check("hold_ready_in_resp", {31'b0, req_ready}, 32'd0);
                if (expq.size() > 0) check("hold_resp", resp_data, expq.pop_front());
                else check("hold_unexpected_resp", 32'd1, 32'd0);
            end
            if (req_ready) begin
                model(op, data, e);
                expq.push_back(e);
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid) begin
                rsp++;
                if (expq.size() > 0) check("drain_resp", resp_data, expq.pop_front());
                else check("drain_unexpected_resp", 32'd1, 32'd0);
            end
            @(negedge clk);
        end
        check("hold_acc_eq_rsp", acc, rsp);
        check("hold_queue_empty", expq.size(), 32'd0);
        check("hold_min_acc", {31'b0, acc >= 4}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
